// File: rtl/cpu6_excp_ctrl.sv
// Trap/return sequencer: prioritises synchronous exceptions and mret, strobes mepc/mcause
// into the CSR file, flushes the pipeline, then redirects fetch via a valid/ack handshake.
module cpu6_excp_ctrl #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic               ex_illinst,
  input  logic               ex_ebreak,
  input  logic               ex_ecall,
  input  logic               ex_mret,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  output logic [XLEN-1:0]    excp_mepc,
  output logic               excp_mepc_ena,
  output logic [CAUSE_W-1:0] excp_mcause,
  output logic               excp_mcause_ena,
  output logic               excp_flush,
  output logic               excp_busy,
  output logic               fe_redirect_valid,
  output logic [XLEN-1:0]    fe_redirect_pc,
  input  logic               fe_redirect_ack
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t state, state_nxt;

  logic               cap_trap;
  logic [CAUSE_W-1:0] cap_cause;
  logic [XLEN-1:1]    cap_pc;
  logic [XLEN-1:0]    cap_target;

  logic               is_trap;
  logic               trigger;
  logic [CAUSE_W-1:0] trap_cause;
  logic               unused_pc_lsb;

  // mepc is always halfword aligned, so the retiring PC's bit 0 is never stored
  assign unused_pc_lsb = ex_pc[0];

  // Exceptions outrank mret; among exceptions illegal > ebreak > ecall
  always_comb begin
    trap_cause = '0;
    is_trap    = ex_illinst | ex_ebreak | ex_ecall;
    if (ex_illinst)     trap_cause = CAUSE_W'(2);
    else if (ex_ebreak) trap_cause = CAUSE_W'(3);
    else if (ex_ecall)  trap_cause = CAUSE_W'(11);
    trigger = ex_valid & (is_trap | ex_mret);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_trap   <= 1'b0;
      cap_cause  <= '0;
      cap_pc     <= '0;
      cap_target <= '0;
    end else if (state == IDLE && trigger) begin
      cap_trap   <= is_trap;
      cap_cause  <= trap_cause;
      cap_pc     <= ex_pc[XLEN-1:1];
      cap_target <= is_trap ? csr_mtvec : csr_mepc;
    end
  end

  // Outputs decode only from state and capture flops, never from ex_*
  always_comb begin
    state_nxt         = state;
    excp_mepc         = '0;
    excp_mepc_ena     = 1'b0;
    excp_mcause       = '0;
    excp_mcause_ena   = 1'b0;
    excp_flush        = 1'b0;
    excp_busy         = 1'b0;
    fe_redirect_valid = 1'b0;
    fe_redirect_pc    = '0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = FLUSH;
      end
      FLUSH: begin
        excp_flush = 1'b1;
        excp_busy  = 1'b1;
        if (cap_trap) begin
          excp_mepc_ena   = 1'b1;
          excp_mepc       = {cap_pc, 1'b0};
          excp_mcause_ena = 1'b1;
          excp_mcause     = cap_cause;
        end
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        excp_busy         = 1'b1;
        fe_redirect_valid = 1'b1;
        fe_redirect_pc    = cap_target;
        if (fe_redirect_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu6_excp_ctrl.sv
// Self-checking bench for cpu6_excp_ctrl: directed scenarios plus randomized traffic
// compared against a trigger-age reference model.
module tb_cpu6_excp_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_illinst;
  logic        ex_ebreak;
  logic        ex_ecall;
  logic        ex_mret;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] excp_mepc;
  logic        excp_mepc_ena;
  logic [3:0]  excp_mcause;
  logic        excp_mcause_ena;
  logic        excp_flush;
  logic        excp_busy;
  logic        fe_redirect_valid;
  logic [31:0] fe_redirect_pc;
  logic        fe_redirect_ack;

  int vectors;
  int miscompares;

  cpu6_excp_ctrl #(.XLEN(32), .CAUSE_W(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_illinst(ex_illinst), .ex_ebreak(ex_ebreak), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena),
    .excp_mcause(excp_mcause), .excp_mcause_ena(excp_mcause_ena),
    .excp_flush(excp_flush), .excp_busy(excp_busy),
    .fe_redirect_valid(fe_redirect_valid), .fe_redirect_pc(fe_redirect_pc),
    .fe_redirect_ack(fe_redirect_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout: flush, mepc_ena, mepc, mcause_ena, mcause, busy, redirect_valid, redirect_pc
  function automatic logic [72:0] pack_exp(input logic fl, input logic me, input logic [31:0] mp,
                                           input logic mce, input logic [3:0] mc, input logic bz,
                                           input logic vl, input logic [31:0] rp);
    return {fl, me, mp, mce, mc, bz, vl, rp};
  endfunction

  function automatic logic [72:0] observed();
    return {excp_flush, excp_mepc_ena, excp_mepc, excp_mcause_ena, excp_mcause,
            excp_busy, fe_redirect_valid, fe_redirect_pc};
  endfunction

  task automatic clear_ex();
    ex_valid   = 1'b0;
    ex_pc      = '0;
    ex_illinst = 1'b0;
    ex_ebreak  = 1'b0;
    ex_ecall   = 1'b0;
    ex_mret    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_ex();
    csr_mtvec = '0;
    csr_mepc = '0;
    fe_redirect_ack = 1'b0;
    #1;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", observed(), 73'h0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_idle: got %h expected %h", observed(), 73'h0);
    end
  endtask

  task automatic test_illegal();
    logic [72:0] exp;
    ex_valid = 1'b1; ex_illinst = 1'b1; ex_pc = 32'h0000_0104; csr_mtvec = 32'h0000_0080;
    @(negedge clk);
    clear_ex();
    exp = pack_exp(1, 1, 32'h104, 1, 4'd2, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL illegal_flush: got %h expected %h", observed(), exp);
    end
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h80);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("[TB] FAIL illegal_redirect_T+%0d: got %h expected %h", c, observed(), exp);
      end
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL illegal_idle_T+5: got %h expected %h", observed(), 73'h0);
    end
  endtask

  task automatic test_priority();
    logic [72:0] exp;
    // all three flags: illegal wins
    ex_valid = 1'b1; ex_illinst = 1'b1; ex_ecall = 1'b1; ex_mret = 1'b1;
    ex_pc = 32'h0000_0020; csr_mtvec = 32'h0000_0080; csr_mepc = 32'h0000_0200;
    @(negedge clk);
    clear_ex();
    exp = pack_exp(1, 1, 32'h20, 1, 4'd2, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL prio_ill_flush: got %h expected %h", observed(), exp);
    end
    @(negedge clk);
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h80);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL prio_ill_redirect: got %h expected %h", observed(), exp);
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
    // ecall beats mret; odd PC checks the forced-zero mepc bit 0
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_mret = 1'b1; ex_pc = 32'h0000_0045;
    @(negedge clk);
    clear_ex();
    exp = pack_exp(1, 1, 32'h44, 1, 4'd11, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL prio_ecall_flush: got %h expected %h", observed(), exp);
    end
    @(negedge clk);
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h80);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL prio_ecall_redirect: got %h expected %h", observed(), exp);
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
  endtask

  task automatic test_mret();
    logic [72:0] exp;
    ex_valid = 1'b1; ex_mret = 1'b1; ex_pc = 32'h0000_0600; csr_mepc = 32'h0000_0200;
    @(negedge clk);
    clear_ex();
    exp = pack_exp(1, 0, 32'h0, 0, 4'd0, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL mret_flush: got %h expected %h", observed(), exp);
    end
    @(negedge clk);
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h200);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL mret_redirect: got %h expected %h", observed(), exp);
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL mret_idle_T+3: got %h expected %h", observed(), 73'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [72:0] exp;
    ex_valid = 1'b1; ex_ecall = 1'b1; ex_pc = 32'h0000_0010; csr_mtvec = 32'h0000_0080;
    @(negedge clk);
    // a second ecall and a moving mtvec are held throughout the busy window
    ex_pc = 32'h0000_0999; csr_mtvec = 32'h0000_0444;
    exp = pack_exp(1, 1, 32'h10, 1, 4'd11, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL busy_flush: got %h expected %h", observed(), exp);
    end
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h80);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("[TB] FAIL busy_redirect_T+%0d: got %h expected %h", c, observed(), exp);
      end
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL busy_first_idle: got %h expected %h", observed(), 73'h0);
    end
    ex_pc = 32'h0000_0300;
    @(negedge clk);
    clear_ex();
    exp = pack_exp(1, 1, 32'h300, 1, 4'd11, 1, 0, 32'h0);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL b2b_flush: got %h expected %h", observed(), exp);
    end
    @(negedge clk);
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h444);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL b2b_redirect: got %h expected %h", observed(), exp);
    end
    fe_redirect_ack = 1'b1;
    @(negedge clk);
    fe_redirect_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [72:0] exp;
    ex_valid = 1'b1; ex_ebreak = 1'b1; ex_pc = 32'h0000_0500; csr_mtvec = 32'h0000_0600;
    @(negedge clk);
    clear_ex();
    @(negedge clk);
    exp = pack_exp(0, 0, 32'h0, 0, 4'd0, 1, 1, 32'h600);
    vectors++;
    if (observed() !== exp) begin
      miscompares++;
      $display("[TB] FAIL rstmid_redirect: got %h expected %h", observed(), exp);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (observed() !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got %h expected %h", observed(), 73'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (observed() !== '0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_after_%0d: got %h expected %h", c, observed(), 73'h0);
      end
    end
  endtask

  task automatic test_no_trigger();
    for (int c = 0; c < 20; c++) begin
      clear_ex();
      ex_pc = $urandom;
      if (c < 10) ex_ecall = 1'b1;
      else        ex_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (observed() !== '0) begin
        miscompares++;
        $display("[TB] FAIL no_trigger_%0d: got %h expected %h", c, observed(), 73'h0);
      end
    end
    clear_ex();
    @(negedge clk);
  endtask

  // Reference: a pending event with its age in cycles since the trigger edge
  task automatic test_random();
    bit          m_pend = 0;
    int          m_age = 0;
    bit          m_trap = 0;
    logic [3:0]  m_cause = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_target = '0;
    logic [72:0] exp;
    bit          strobe, redir;
    for (int c = 0; c < 400; c++) begin
      strobe = m_pend && m_age == 1 && m_trap;
      redir  = m_pend && m_age >= 2;
      exp = pack_exp(m_pend && m_age == 1, strobe, strobe ? (m_pc & ~32'h1) : 32'h0,
                     strobe, strobe ? m_cause : 4'd0, m_pend, redir, redir ? m_target : 32'h0);
      vectors++;
      if (observed() !== exp) begin
        miscompares++;
        $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, observed(), exp);
      end
      ex_valid   = ($urandom_range(0, 9) < 7);
      ex_illinst = ($urandom_range(0, 9) < 2);
      ex_ebreak  = ($urandom_range(0, 9) < 2);
      ex_ecall   = ($urandom_range(0, 9) < 2);
      ex_mret    = ($urandom_range(0, 9) < 3);
      ex_pc      = $urandom;
      csr_mtvec  = $urandom;
      csr_mepc   = $urandom;
      fe_redirect_ack = ($urandom_range(0, 9) < 4);
      if (m_pend) begin
        if (m_age >= 2 && fe_redirect_ack) m_pend = 0;
        else m_age++;
      end else if (ex_valid && (ex_illinst || ex_ebreak || ex_ecall || ex_mret)) begin
        m_pend   = 1;
        m_age    = 1;
        m_trap   = ex_illinst || ex_ebreak || ex_ecall;
        m_cause  = ex_illinst ? 4'd2 : ex_ebreak ? 4'd3 : ex_ecall ? 4'd11 : 4'd0;
        m_pc     = ex_pc;
        m_target = m_trap ? csr_mtvec : csr_mepc;
      end
      @(negedge clk);
    end
    clear_ex();
    fe_redirect_ack = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_illegal();
    test_priority();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    test_no_trigger();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
